sync_param_fifo: RTL and testbench

//  Single-clock, parametrised-width/depth FIFO; successor to the 2-entry push/full, pop/empty FIFO.

---
 rtl/sync_param_fifo_pkg.sv | 22 ++
 rtl/fifo_mem_2p.sv | 33 +++
 rtl/sync_param_fifo.sv | 157 +++++++++++++++
 tb/tb_sync_param_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_param_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the parametrised sync FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Sticky error flags reported by the FIFO
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Advance a pointer by one, wrapping at depth-1 back to 0 (any depth)
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem_2p
//  Description : DEPTH x WIDTH storage, one synchronous write port and one
//                asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int c_AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [c_AW-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [c_AW-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store data on an accepted push
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_param_fifo
//  Description : Single-clock FIFO with programmable almost-full/empty levels,
//                occupancy count, sticky overflow/underflow and selectable
//                first-word-fall-through or registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 1,
    localparam int c_CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             almost_full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             empty,
    output logic             almost_empty,
    output logic [c_CW-1:0]  count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int c_PW = $clog2(DEPTH);

    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    fifo_err_t        r_err;
    logic             w_acc_push;
    logic             w_acc_pop;
    logic [WIDTH-1:0] w_mem_rdata;

    // Requests are only honoured against the registered flags of this cycle
    assign w_acc_push = push & ~r_full;
    assign w_acc_pop  = pop  & ~r_empty;

    // Next occupancy; simultaneous push and pop leave the count unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_acc_push, w_acc_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and flags; flags are registered from the next count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (AF_LEVEL == 0);
            r_almost_empty <= 1'b1;
        end else begin
            if (w_acc_push) begin
                r_wr_ptr <= c_PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_acc_pop) begin
                r_rd_ptr <= c_PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_CW'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (int'(w_count_nxt) >= AF_LEVEL);
            r_almost_empty <= (int'(w_count_nxt) <= AE_LEVEL);
        end
    end

    // Sticky errors; a fresh error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            if (push & r_full) begin
                r_err.overflow <= 1'b1;
            end else if (clr_err) begin
                r_err.overflow <= 1'b0;
            end
            if (pop & r_empty) begin
                r_err.underflow <= 1'b1;
            end else if (clr_err) begin
                r_err.underflow <= 1'b0;
            end
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_acc_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so stale
            // storage never appears on the output
            assign rdata  = r_empty ? '0 : w_mem_rdata;
            assign rvalid = ~r_empty;
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rdata;
            logic             r_rvalid;

            // Registered read: capture the head word on an accepted pop
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_acc_pop;
                    if (w_acc_pop) begin
                        r_rdata <= w_mem_rdata;
                    end
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate

    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_param_fifo
//  Description : Self-checking bench; a DEPTH=4 FWFT instance and a DEPTH=3
//                registered-read instance checked against a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_param_fifo;

    logic clk;
    logic reset;

    // Instance A: DEPTH=4, FWFT=1
    logic       a_push, a_pop, a_clr;
    logic [7:0] a_wdata, a_rdata;
    logic       a_full, a_af, a_empty, a_ae, a_rvalid, a_ovf, a_udf;
    logic [2:0] a_count;

    // Instance B: DEPTH=3, FWFT=0
    logic       b_push, b_pop, b_clr;
    logic [7:0] b_wdata, b_rdata;
    logic       b_full, b_af, b_empty, b_ae, b_rvalid, b_ovf, b_udf;
    logic [1:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    sync_param_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1)) dut_a (
        .clk(clk), .reset(reset), .push(a_push), .wdata(a_wdata),
        .full(a_full), .almost_full(a_af), .pop(a_pop), .rdata(a_rdata),
        .rvalid(a_rvalid), .empty(a_empty), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_udf), .clr_err(a_clr)
    );

    sync_param_fifo #(.WIDTH(8), .DEPTH(3), .FWFT(0)) dut_b (
        .clk(clk), .reset(reset), .push(b_push), .wdata(b_wdata),
        .full(b_full), .almost_full(b_af), .pop(b_pop), .rdata(b_rdata),
        .rvalid(b_rvalid), .empty(b_empty), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_udf), .clr_err(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({a_empty, a_full, a_count, a_rvalid, a_ovf, a_udf, a_ae, a_af} !== 10'b1_0_000_0_0_0_1_0) begin
            n_fail++;
            $display("FAIL reset_a got=%b exp=%b", {a_empty, a_full, a_count, a_rvalid, a_ovf, a_udf, a_ae, a_af}, 10'b1_0_000_0_0_0_1_0);
        end
        n_checks++;
        if ({b_empty, b_full, b_count, b_rvalid, b_ovf, b_udf, b_rdata} !== {6'b1_0_00_0_0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_b got=%b exp=%b", {b_empty, b_full, b_count, b_rvalid, b_ovf, b_udf, b_rdata}, {6'b1_0_00_0_0, 1'b0, 8'h00});
        end
        n_checks++;
        if (a_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_a_rdata got=%h exp=00", a_rdata);
        end
    endtask

    task automatic test_fill();
        logic [7:0] d;
        for (int i = 1; i <= 4; i++) begin
            d = 8'hA0 + 8'(i);
            a_push  = 1'b1;
            a_wdata = d;
            q_a.push_back(d);
            tick();
            n_checks++;
            if ({a_count, a_af, a_full, a_ae} !== {3'(i), (i >= 3), (i == 4), (i <= 1)}) begin
                n_fail++;
                $display("FAIL fill_%0d count/af/full/ae got=%b exp=%b", i, {a_count, a_af, a_full, a_ae}, {3'(i), (i >= 3), (i == 4), (i <= 1)});
            end
            n_checks++;
            if (a_rdata !== 8'hA1 || a_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_%0d head got=%h/%b exp=a1/1", i, a_rdata, a_rvalid);
            end
        end
        a_push = 1'b0;
    endtask

    task automatic test_overflow();
        a_push  = 1'b1;
        a_wdata = 8'hFF;
        tick();
        a_push = 1'b0;
        n_checks++;
        if ({a_count, a_ovf, a_full, a_rdata} !== {3'd4, 1'b1, 1'b1, q_a[0]}) begin
            n_fail++;
            $display("FAIL overflow got=%b exp=%b", {a_count, a_ovf, a_full, a_rdata}, {3'd4, 1'b1, 1'b1, q_a[0]});
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        n_checks++;
        if (a_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_err got=%b exp=0", a_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        exp = q_a.pop_front();
        n_checks++;
        if (a_rdata !== exp) begin
            n_fail++;
            $display("FAIL full_pp_head got=%h exp=%h", a_rdata, exp);
        end
        a_push  = 1'b1;
        a_pop   = 1'b1;
        a_wdata = 8'h55;
        tick();
        a_push = 1'b0;
        a_pop  = 1'b0;
        n_checks++;
        if ({a_count, a_ovf, a_full, a_af} !== {3'd3, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_pp got=%b exp=%b", {a_count, a_ovf, a_full, a_af}, {3'd3, 1'b1, 1'b0, 1'b1});
        end
        // Drain; the dropped 0x55 must never appear
        while (q_a.size() > 0) begin
            exp = q_a.pop_front();
            n_checks++;
            if (a_rdata !== exp || a_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain got=%h/%b exp=%h/1", a_rdata, a_rvalid, exp);
            end
            a_pop = 1'b1;
            tick();
            a_pop = 1'b0;
        end
        n_checks++;
        if ({a_empty, a_count, a_rvalid} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL drained got=%b exp=%b", {a_empty, a_count, a_rvalid}, {1'b1, 3'd0, 1'b0});
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    task automatic test_empty_push_pop();
        a_push  = 1'b1;
        a_pop   = 1'b1;
        a_wdata = 8'h33;
        q_a.push_back(8'h33);
        tick();
        a_push = 1'b0;
        a_pop  = 1'b0;
        n_checks++;
        if ({a_count, a_udf, a_empty, a_rvalid, a_rdata} !== {3'd1, 1'b1, 1'b0, 1'b1, q_a[0]}) begin
            n_fail++;
            $display("FAIL empty_pp got=%b exp=%b", {a_count, a_udf, a_empty, a_rvalid, a_rdata}, {3'd1, 1'b1, 1'b0, 1'b1, q_a[0]});
        end
        void'(q_a.pop_front());
        a_pop = 1'b1;
        tick();
        a_pop = 1'b0;
        n_checks++;
        if ({a_empty, a_count} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL empty_pp_drain got=%b exp=%b", {a_empty, a_count}, {1'b1, 3'd0});
        end
    endtask

    task automatic test_mid_reset();
        a_push  = 1'b1;
        a_wdata = 8'h11;
        tick();
        a_wdata = 8'h22;
        tick();
        a_push = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({a_count, a_empty, a_rvalid, a_udf, a_rdata} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset got=%b exp=%b", {a_count, a_empty, a_rvalid, a_udf, a_rdata}, {3'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
    endtask

    task automatic test_registered_wrap();
        logic [7:0] exp;
        logic [7:0] last;
        last = 8'h00;
        for (int i = 0; i < 7; i++) begin
            b_push  = 1'b1;
            b_wdata = 8'hC0 + 8'(i);
            q_b.push_back(b_wdata);
            tick();
            b_push = 1'b0;
            n_checks++;
            if ({b_count, b_rvalid, b_rdata} !== {2'd1, 1'b0, last}) begin
                n_fail++;
                $display("FAIL wrap_push_%0d got=%b exp=%b", i, {b_count, b_rvalid, b_rdata}, {2'd1, 1'b0, last});
            end
            b_pop = 1'b1;
            tick();
            b_pop = 1'b0;
            exp  = q_b.pop_front();
            last = exp;
            n_checks++;
            if ({b_rvalid, b_rdata, b_count} !== {1'b1, exp, 2'd0}) begin
                n_fail++;
                $display("FAIL wrap_pop_%0d got=%b exp=%b", i, {b_rvalid, b_rdata, b_count}, {1'b1, exp, 2'd0});
            end
            tick();
            n_checks++;
            if ({b_rvalid, b_rdata} !== {1'b0, last}) begin
                n_fail++;
                $display("FAIL wrap_hold_%0d got=%b exp=%b", i, {b_rvalid, b_rdata}, {1'b0, last});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_wdata = '0;
        b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_wdata = '0;
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_mid_reset();
        test_registered_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
